kf8259_irq_capture: RTL and testbench
=====================================

KF8259_IRQ_CAPTURE -- requirements
Module: kf8259_irq_capture

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 0..3; 0 = pins used directly).
REQ-003 SHALL have derived localparam IDX_W = max(1, clog2(NUM_IRQ)).
REQ-004 SHALL have ports, clock and reset first:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- interrupt_request_pin  in  NUM_IRQ  raw request inputs
- trigger_mode  in  2*NUM_IRQ  per channel [2i+1:2i]: 00 rising edge, 01 falling edge, 10 high level, 11 low level
- interrupt_mask  in  NUM_IRQ  1 = channel excluded from resolution only
- freeze  in  1  hold interrupt_request_register
- clear_interrupt_request  in  NUM_IRQ  per-channel clear
- irq_ack  in  1  consumer accepts irq_index
- interrupt_request_register  out  NUM_IRQ  pending requests
- irq_valid  out  1  unmasked request pending
- irq_index  out  IDX_W  highest-priority pending channel
REQ-005 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-006 Each channel SHALL pass through SYNC_STAGES flops; result s[i]; flop p[i] SHALL hold s[i] of the previous cycle.
REQ-007 Edge event: rising = s & ~p; falling = ~s & p; level active: high = s, low = ~s.
REQ-008 Edge modes: register bit SHALL set on an edge event and hold until cleared; a further edge while set SHALL have no effect.
REQ-009 Level modes: register bit SHALL follow the level-active term every cycle (not latched).
REQ-010 Clear SHALL beat set: clear_interrupt_request[i], or irq_ack with irq_valid and irq_index==i in an edge mode, SHALL zero bit i next cycle even with a simultaneous edge.
REQ-011 irq_ack SHALL NOT clear a level-mode bit; source must deassert.
REQ-012 While freeze=1, register SHALL hold except for clears (REQ-010); edge events during freeze SHALL be stored in per-channel edge_hold and merged into the register on the first cycle after freeze deasserts.
REQ-013 A clear of channel i during freeze SHALL also zero edge_hold[i].
REQ-014 Latency, SYNC_STAGES=0: pin edge sampled at clock n SHALL make the register bit visible after clock n+1; each sync stage SHALL add one cycle.
REQ-015 irq_valid/irq_index SHALL be registered from next-state(register) & ~interrupt_mask, so they are visible in the same cycle as the register and an acked index never reappears the cycle after ack.
REQ-016 Priority SHALL be fixed: lowest index wins; irq_index SHALL be 0 when irq_valid=0.
REQ-017 irq_ack while irq_valid=0 SHALL be ignored.
REQ-018 trigger_mode changes SHALL take effect next cycle; register bit SHALL retain its value across a mode change until updated under the new mode.
REQ-019 Masking SHALL NOT alter interrupt_request_register or edge capture.

Reset
REQ-020 Reset SHALL zero sync flops, p, edge_hold, interrupt_request_register, irq_valid, irq_index.
REQ-021 Reset mid-operation SHALL discard pending edges and edge_hold in one cycle; a pin held high through reset SHALL produce a rising edge SYNC_STAGES+1 cycles after release.
REQ-022 Reset SHALL take priority over freeze, clear and ack.

Verification
REQ-023 SYNC_STAGES=2, ch3 rising: pin3 0->1 at clock n -> register=0x08, irq_valid=1, irq_index=3 after clock n+3; pin back to 0 -> stays 0x08.
REQ-024 ch1 and ch5 rising edges same cycle -> irq_index=1; irq_ack -> next cycle register=0x20, irq_index=5; second ack -> irq_valid=0.
REQ-025 ch2 high level: pin2 high -> bit set; irq_ack -> bit stays 1; pin2 low -> bit 0 after sync latency.
REQ-026 freeze=1, edge on ch0, freeze=0 two cycles later -> register bit0 stays 0 during freeze, 1 on first cycle after release; repeat with clear[0] during freeze -> bit0 stays 0.
REQ-027 clear_interrupt_request[4] in same cycle as ch4 edge detection -> bit4 = 0; interrupt_mask=0xFF with pending 0x10 -> register=0x10, irq_valid=0.
REQ-028 NUM_IRQ=16, SYNC_STAGES=0, ch15 falling edge -> irq_index=15 one cycle later; reset asserted same cycle -> all outputs 0.

Source files
------------

// File: rtl/kf8259_irq_capture.sv
// Interrupt request capture for an 8259-style controller: synchronises the pins, detects
// edges or levels per channel and registers the highest-priority unmasked pending request.
module kf8259_irq_capture #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     interrupt_request_pin,
  input  logic [2*NUM_IRQ-1:0]   trigger_mode,
  input  logic [NUM_IRQ-1:0]     interrupt_mask,
  input  logic                   freeze,
  input  logic [NUM_IRQ-1:0]     clear_interrupt_request,
  input  logic                   irq_ack,
  output logic [NUM_IRQ-1:0]     interrupt_request_register,
  output logic                   irq_valid,
  output logic [IDX_W-1:0]       irq_index
);

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] p_q;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] hold_q, hold_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   index_q, index_d;

  logic [NUM_IRQ-1:0] edge_ev;
  logic [NUM_IRQ-1:0] lvl_act;
  logic [NUM_IRQ-1:0] is_level;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pend;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      always_comb s = interrupt_request_pin;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= interrupt_request_pin;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      always_comb s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Per-channel event terms; acks only clear edge-mode bits of the currently presented index.
  always_comb begin
    edge_ev  = '0;
    lvl_act  = '0;
    is_level = '0;
    clr      = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      is_level[i] = trigger_mode[2*i+1];
      lvl_act[i]  = trigger_mode[2*i] ? ~s[i] : s[i];
      if (!trigger_mode[2*i+1]) begin
        edge_ev[i] = trigger_mode[2*i] ? (~s[i] & p_q[i]) : (s[i] & ~p_q[i]);
      end
      clr[i] = clear_interrupt_request[i] |
               (irq_ack & valid_q & (index_q == IDX_W'(i)) & ~trigger_mode[2*i+1]);
    end
  end

  always_comb begin
    irr_d  = irr_q;
    hold_d = hold_q;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (clr[i]) begin
        irr_d[i]  = 1'b0;
        hold_d[i] = 1'b0;
      end else if (freeze) begin
        hold_d[i] = hold_q[i] | edge_ev[i];
      end else if (is_level[i]) begin
        irr_d[i]  = lvl_act[i];
        hold_d[i] = 1'b0;
      end else begin
        irr_d[i]  = irr_q[i] | edge_ev[i] | hold_q[i];
        hold_d[i] = 1'b0;
      end
    end
  end

  // Resolve from the next register value so an acked index never lingers a cycle.
  always_comb begin
    pend    = irr_d & ~interrupt_mask;
    valid_d = 1'b0;
    index_d = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pend[i] && !valid_d) begin
        valid_d = 1'b1;
        index_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q     <= '0;
      irr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      p_q     <= s;
      irr_q   <= irr_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    interrupt_request_register = irr_q;
    irq_valid                  = valid_q;
    irq_index                  = index_q;
  end

endmodule

// File: tb/tb_kf8259_irq_capture.sv
// Directed bench: default 8-channel/2-stage instance plus a 16-channel unsynchronised instance.
module tb_kf8259_irq_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Instance A: NUM_IRQ=8, SYNC_STAGES=2
  logic [7:0]  pin_a, mask_a, clr_a, irr_a;
  logic [15:0] mode_a;
  logic        frz_a, ack_a, val_a;
  logic [2:0]  idx_a;

  // Instance B: NUM_IRQ=16, SYNC_STAGES=0
  logic [15:0] pin_b, mask_b, clr_b, irr_b;
  logic [31:0] mode_b;
  logic        frz_b, ack_b, val_b;
  logic [3:0]  idx_b;

  kf8259_irq_capture #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut_a (
    .clock                      (clk),
    .reset                      (rst),
    .interrupt_request_pin      (pin_a),
    .trigger_mode               (mode_a),
    .interrupt_mask             (mask_a),
    .freeze                     (frz_a),
    .clear_interrupt_request    (clr_a),
    .irq_ack                    (ack_a),
    .interrupt_request_register (irr_a),
    .irq_valid                  (val_a),
    .irq_index                  (idx_a)
  );

  kf8259_irq_capture #(.NUM_IRQ(16), .SYNC_STAGES(0)) dut_b (
    .clock                      (clk),
    .reset                      (rst),
    .interrupt_request_pin      (pin_b),
    .trigger_mode               (mode_b),
    .interrupt_mask             (mask_b),
    .freeze                     (frz_b),
    .clear_interrupt_request    (clr_b),
    .irq_ack                    (ack_b),
    .interrupt_request_register (irr_b),
    .irq_valid                  (val_b),
    .irq_index                  (idx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] irr, input logic v, input logic [2:0] ix);
    check({tag, ".irr"}, 32'(irr_a), 32'(irr));
    check({tag, ".valid"}, 32'(val_a), 32'(v));
    check({tag, ".index"}, 32'(idx_a), 32'(ix));
  endtask

  initial begin
    rst    = 1'b1;
    pin_a  = '0; mask_a = '0; clr_a = '0; frz_a = 1'b0; ack_a = 1'b0;
    mode_a = 16'h0020;                       // ch2 high level, others rising edge
    pin_b  = 16'h8000; mask_b = '0; clr_b = '0; frz_b = 1'b0; ack_b = 1'b0;
    mode_b = 32'h4000_0000;                  // ch15 falling edge, others rising edge

    tick(2);
    check_a("reset", 8'h00, 1'b0, 3'd0);
    rst = 1'b0;
    tick(1);
    check("b_rise_in_fall_mode", 32'(irr_b), 32'h0);

    // ch3 rising edge through two sync stages
    pin_a[3] = 1'b1;
    tick(2);
    check("ch3_lat_n2", 32'(irr_a), 32'h00);
    tick(1);
    check_a("ch3_lat_n3", 8'h08, 1'b1, 3'd3);
    pin_a[3] = 1'b0;
    tick(3);
    check("ch3_hold", 32'(irr_a), 32'h08);
    clr_a[3] = 1'b1; tick(1); clr_a[3] = 1'b0;
    check_a("ch3_clear", 8'h00, 1'b0, 3'd0);

    // ch1 and ch5 simultaneous, ack sequence
    pin_a[1] = 1'b1; pin_a[5] = 1'b1;
    tick(3);
    check_a("dual", 8'h22, 1'b1, 3'd1);
    ack_a = 1'b1; tick(1); ack_a = 1'b0;
    check_a("ack1", 8'h20, 1'b1, 3'd5);
    ack_a = 1'b1; tick(1); ack_a = 1'b0;
    check_a("ack2", 8'h00, 1'b0, 3'd0);
    pin_a[1] = 1'b0; pin_a[5] = 1'b0;
    tick(3);
    check("dual_fall", 32'(irr_a), 32'h00);

    // ch2 high level
    pin_a[2] = 1'b1;
    tick(3);
    check_a("lvl_set", 8'h04, 1'b1, 3'd2);
    ack_a = 1'b1; tick(1); ack_a = 1'b0;
    check("lvl_ack", 32'(irr_a), 32'h04);
    pin_a[2] = 1'b0;
    tick(2);
    check("lvl_fall_n2", 32'(irr_a), 32'h04);
    tick(1);
    check("lvl_fall_n3", 32'(irr_a), 32'h00);

    // freeze with edge on ch0
    frz_a = 1'b1; pin_a[0] = 1'b1;
    tick(3);
    check("frz_n3", 32'(irr_a), 32'h00);
    tick(1);
    check("frz_n4", 32'(irr_a), 32'h00);
    frz_a = 1'b0;
    tick(1);
    check_a("frz_release", 8'h01, 1'b1, 3'd0);
    clr_a[0] = 1'b1; tick(1); clr_a[0] = 1'b0;
    pin_a[0] = 1'b0;
    tick(3);
    check("frz_cleanup", 32'(irr_a), 32'h00);

    // freeze with clear of the held edge
    frz_a = 1'b1; pin_a[0] = 1'b1;
    tick(4);
    clr_a[0] = 1'b1; tick(1); clr_a[0] = 1'b0;
    frz_a = 1'b0;
    tick(1);
    check_a("frz_clr_rel", 8'h00, 1'b0, 3'd0);
    tick(1);
    check("frz_clr_rel2", 32'(irr_a), 32'h00);
    pin_a[0] = 1'b0;
    tick(3);

    // clear coinciding with ch4 edge detection
    pin_a[4] = 1'b1;
    tick(2);
    clr_a[4] = 1'b1; tick(1); clr_a[4] = 1'b0;
    check("clr_vs_set", 32'(irr_a), 32'h00);
    tick(1);
    check("clr_vs_set2", 32'(irr_a), 32'h00);
    pin_a[4] = 1'b0;
    tick(3);
    pin_a[4] = 1'b1;
    tick(3);
    check_a("ch4_set", 8'h10, 1'b1, 3'd4);
    mask_a = 8'hFF;
    tick(1);
    check_a("masked", 8'h10, 1'b0, 3'd0);
    ack_a = 1'b1; tick(1); ack_a = 1'b0;
    check_a("ack_ignored", 8'h10, 1'b0, 3'd0);
    mask_a = 8'h00;
    tick(1);
    check_a("unmasked", 8'h10, 1'b1, 3'd4);

    // reset mid-operation with pin4 held high, with freeze asserted
    rst = 1'b1; frz_a = 1'b1;
    tick(1);
    check_a("mid_reset", 8'h00, 1'b0, 3'd0);
    rst = 1'b0; frz_a = 1'b0;
    tick(2);
    check("post_rst_n2", 32'(irr_a), 32'h00);
    tick(1);
    check_a("post_rst_n3", 8'h10, 1'b1, 3'd4);

    // instance B: ch15 falling edge with no synchroniser
    pin_b[15] = 1'b0;
    tick(1);
    check("b_fall.irr", 32'(irr_b), 32'h8000);
    check("b_fall.valid", 32'(val_b), 32'h1);
    check("b_fall.index", 32'(idx_b), 32'd15);
    clr_b[15] = 1'b1; tick(1); clr_b[15] = 1'b0;
    check("b_clear", 32'(irr_b), 32'h0);
    pin_b[15] = 1'b1;
    tick(2);
    pin_b[15] = 1'b0; rst = 1'b1;
    tick(1);
    check("b_rst.irr", 32'(irr_b), 32'h0);
    check("b_rst.valid", 32'(val_b), 32'h0);
    check("b_rst.index", 32'(idx_b), 32'h0);
    rst = 1'b0;
    tick(1);
    check("b_after_rst", 32'(irr_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
